// File: rtl/ahb_decode_pkg.sv
// ahb_decode_pkg
//   Shared constants and types for the AHB-Lite address decoder:
//   htrans encodings, data-phase select encodings, hresp values and the
//   default-slave state type.
package ahb_decode_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] SEL_S1  = 3'b000;
  localparam logic [2:0] SEL_S2  = 3'b001;
  localparam logic [2:0] SEL_S3  = 3'b010;
  localparam logic [2:0] SEL_DEF = 3'b011;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    ERR1 = 2'b01,
    ERR2 = 2'b10
  } def_state_t;

endpackage

// File: rtl/ahb_default_slave.sv
// ahb_default_slave
//   Internal default slave: answers transfers to unmapped addresses with the
//   AHB two-cycle ERROR response. Optional saturating count of error entries
//   when DECODE_ERR_CNT_EN is defined.
//
//   state | meaning
//   IDLE  | no error in progress, hreadyout=1, hresp=OKAY
//   ERR1  | first error cycle, hreadyout=0, hresp=ERROR
//   ERR2  | second error cycle, hreadyout=1, hresp=ERROR
//
// Ports:
//   hclk, hreset      clock and synchronous active-high reset
//   i_hready          system hready
//   i_active          current address phase is NONSEQ or SEQ
//   i_dec_default     current address decodes to no slave
//   o_hreadyout       default-slave hreadyout
//   o_hresp           default-slave hresp
//   o_err_count       saturating ERR1 entry count (DECODE_ERR_CNT_EN only)
module ahb_default_slave
  import ahb_decode_pkg::*;
(
  input  logic        hclk,
  input  logic        hreset,
  input  logic        i_hready,
  input  logic        i_active,
  input  logic        i_dec_default,
  output logic        o_hreadyout,
  output logic        o_hresp
`ifdef DECODE_ERR_CNT_EN
  ,
  output logic [15:0] o_err_count
`endif
);

  def_state_t r_state;
  def_state_t w_state_next;
  logic       w_err_req;

  assign w_err_req = i_hready && i_dec_default && i_active;

  always_ff @(posedge hclk) begin
    if (hreset) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  // Outputs decode from state only, so hready never reaches them combinationally.
  always_comb begin
    w_state_next = IDLE;
    o_hreadyout  = 1'b1;
    o_hresp      = HRESP_OKAY;
    unique case (r_state)
      IDLE: begin
        if (w_err_req) w_state_next = ERR1;
      end
      ERR1: begin
        o_hreadyout  = 1'b0;
        o_hresp      = HRESP_ERROR;
        w_state_next = ERR2;
      end
      ERR2: begin
        o_hresp = HRESP_ERROR;
        if (w_err_req) w_state_next = ERR1;
      end
      default: w_state_next = IDLE;
    endcase
  end

`ifdef DECODE_ERR_CNT_EN
  logic [15:0] r_err_count;

  always_ff @(posedge hclk) begin
    if (hreset)
      r_err_count <= 16'd0;
    else if ((w_state_next == ERR1) && (r_err_count != 16'hFFFF))
      r_err_count <= r_err_count + 16'd1;
  end

  assign o_err_count = r_err_count;
`endif

endmodule

// File: rtl/ahb_addr_decoder.sv
// ahb_addr_decoder
//   AHB-Lite address decoder. Combinational one-hot slave selects in the
//   address phase, a registered data-phase select for the response mux, and
//   an internal default slave for unmapped addresses.
//   Optional feature macro: DECODE_ERR_CNT_EN (adds err_count output).
//
// Ports:
//   hclk, hreset          clock and synchronous active-high reset
//   haddr, htrans         address-phase address and transfer type
//   hready                system hready from the response mux
//   hsel_1..hsel_3        address-phase slave selects
//   sel                   data-phase select (000 s1, 001 s2, 010 s3, 011 default)
//   def_hreadyout         default-slave hreadyout
//   def_hresp             default-slave hresp
//   err_count             saturating error count (DECODE_ERR_CNT_EN only)
module ahb_addr_decoder
  import ahb_decode_pkg::*;
#(
  parameter logic [31:0] S1_BASE   = 32'h0000_0000,
  parameter logic [31:0] S2_BASE   = 32'h0001_0000,
  parameter logic [31:0] S3_BASE   = 32'h0002_0000,
  parameter logic [31:0] ADDR_MASK = 32'hFFFF_0000
) (
  input  logic        hclk,
  input  logic        hreset,
  input  logic [31:0] haddr,
  input  logic [1:0]  htrans,
  input  logic        hready,
  output logic        hsel_1,
  output logic        hsel_2,
  output logic        hsel_3,
  output logic [2:0]  sel,
  output logic        def_hreadyout,
  output logic        def_hresp
`ifdef DECODE_ERR_CNT_EN
  ,
  output logic [15:0] err_count
`endif
);

  logic       w_match1, w_match2, w_match3;
  logic [2:0] w_dec_sel;
  logic       w_dec_default;
  logic       w_active;
  logic [2:0] r_sel;

  assign w_match1 = ((haddr & ADDR_MASK) == (S1_BASE & ADDR_MASK));
  assign w_match2 = ((haddr & ADDR_MASK) == (S2_BASE & ADDR_MASK));
  assign w_match3 = ((haddr & ADDR_MASK) == (S3_BASE & ADDR_MASK));

  // Priority chain keeps the selects one-hot even if regions overlap.
  always_comb begin
    w_dec_sel = SEL_DEF;
    if      (w_match1) w_dec_sel = SEL_S1;
    else if (w_match2) w_dec_sel = SEL_S2;
    else if (w_match3) w_dec_sel = SEL_S3;
  end

  assign hsel_1        = (w_dec_sel == SEL_S1);
  assign hsel_2        = (w_dec_sel == SEL_S2);
  assign hsel_3        = (w_dec_sel == SEL_S3);
  assign w_dec_default = (w_dec_sel == SEL_DEF);
  assign w_active      = (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);

  // Resetting to the default slave keeps system hready high out of reset.
  always_ff @(posedge hclk) begin
    if (hreset)      r_sel <= SEL_DEF;
    else if (hready) r_sel <= w_dec_sel;
  end

  assign sel = r_sel;

  ahb_default_slave u_def_slave (
    .hclk          (hclk),
    .hreset        (hreset),
    .i_hready      (hready),
    .i_active      (w_active),
    .i_dec_default (w_dec_default),
    .o_hreadyout   (def_hreadyout),
    .o_hresp       (def_hresp)
`ifdef DECODE_ERR_CNT_EN
    ,
    .o_err_count   (err_count)
`endif
  );

endmodule

// File: tb/tb_ahb_addr_decoder.sv
module tb_ahb_addr_decoder;

  logic        hclk;
  logic        hreset;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hready;
  logic        hsel_1, hsel_2, hsel_3;
  logic [2:0]  sel;
  logic        def_hreadyout;
  logic        def_hresp;
`ifdef DECODE_ERR_CNT_EN
  logic [15:0] err_count;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: which slave owns the data phase, and how many error
  // response cycles remain (2 = first cycle, 1 = second cycle, 0 = none).
  int          m_slave;
  int          m_err_left;
  int unsigned m_cnt;

  ahb_addr_decoder dut (
    .hclk          (hclk),
    .hreset        (hreset),
    .haddr         (haddr),
    .htrans        (htrans),
    .hready        (hready),
    .hsel_1        (hsel_1),
    .hsel_2        (hsel_2),
    .hsel_3        (hsel_3),
    .sel           (sel),
    .def_hreadyout (def_hreadyout),
    .def_hresp     (def_hresp)
`ifdef DECODE_ERR_CNT_EN
    ,
    .err_count     (err_count)
`endif
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  // Region owner from plain address ranges: 0=s1, 1=s2, 2=s3, 3=unmapped.
  function automatic int owner(input logic [31:0] a);
    if (a < 32'h0001_0000) return 0;
    if (a < 32'h0002_0000) return 1;
    if (a < 32'h0003_0000) return 2;
    return 3;
  endfunction

  // One clock edge with the currently driven inputs; model follows the edge.
  task automatic tick();
    bit req;
    @(posedge hclk);
    req = hready && (owner(haddr) == 3) && htrans[1];
    if (hreset) begin
      m_slave    = 3;
      m_err_left = 0;
      m_cnt      = 0;
    end else begin
      if (hready) m_slave = owner(haddr);
      if (m_err_left == 2)  m_err_left = 1;
      else if (req)         m_err_left = 2;
      else                  m_err_left = 0;
      if (m_err_left == 2 && m_cnt < 65535) m_cnt++;
    end
    #1;
  endtask

  task automatic test_reset();
    hreset = 1'b1; haddr = 32'h0005_0000; htrans = 2'b00; hready = 1'b1;
    tick(); tick();
    hreset = 1'b0;
    #1;
    n_cmp++; if (sel !== 3'b011) begin n_bad++; $display("FAIL reset_sel got=%b exp=011", sel); end
    n_cmp++; if (def_hreadyout !== 1'b1) begin n_bad++; $display("FAIL reset_hreadyout got=%b exp=1", def_hreadyout); end
    n_cmp++; if (def_hresp !== 1'b0) begin n_bad++; $display("FAIL reset_hresp got=%b exp=0", def_hresp); end
    n_cmp++; if ({hsel_1, hsel_2, hsel_3} !== 3'b000) begin n_bad++; $display("FAIL reset_hsel got=%b exp=000", {hsel_1, hsel_2, hsel_3}); end
  endtask

  task automatic test_mapped_decode();
    haddr = 32'h0001_0040; htrans = 2'b10; hready = 1'b1;
    #1;
    n_cmp++; if ({hsel_1, hsel_2, hsel_3} !== 3'b010) begin n_bad++; $display("FAIL map_hsel got=%b exp=010", {hsel_1, hsel_2, hsel_3}); end
    tick();
    n_cmp++; if (sel !== 3'b001) begin n_bad++; $display("FAIL map_sel got=%b exp=001", sel); end
    hready = 1'b0; haddr = 32'h0002_0000; htrans = 2'b10;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++; if (sel !== 3'b001) begin n_bad++; $display("FAIL map_wait_sel cycle=%0d got=%b exp=001", i, sel); end
    end
    hready = 1'b1; htrans = 2'b00;
    tick();
    n_cmp++; if (sel !== 3'b010) begin n_bad++; $display("FAIL map_sel_s3 got=%b exp=010", sel); end
  endtask

  task automatic test_unmapped_error();
    haddr = 32'h0005_0000; htrans = 2'b10; hready = 1'b1;
    tick();
    n_cmp++; if ({def_hreadyout, def_hresp} !== 2'b01) begin n_bad++; $display("FAIL err1_resp got=%b exp=01", {def_hreadyout, def_hresp}); end
    n_cmp++; if (sel !== 3'b011) begin n_bad++; $display("FAIL err_sel got=%b exp=011", sel); end
    htrans = 2'b00; hready = 1'b0;
    tick();
    n_cmp++; if ({def_hreadyout, def_hresp} !== 2'b11) begin n_bad++; $display("FAIL err2_resp got=%b exp=11", {def_hreadyout, def_hresp}); end
    hready = 1'b1;
    tick();
    n_cmp++; if ({def_hreadyout, def_hresp} !== 2'b10) begin n_bad++; $display("FAIL err_idle_resp got=%b exp=10", {def_hreadyout, def_hresp}); end
  endtask

  task automatic test_back_to_back();
    logic [1:0] exp_seq [5];
    exp_seq = '{2'b01, 2'b11, 2'b01, 2'b11, 2'b10};
    for (int i = 0; i < 5; i++) begin
      hready = (i == 1 || i == 3) ? 1'b0 : 1'b1;
      haddr  = 32'h0009_0000;
      htrans = (i == 0 || i == 2) ? 2'b10 : 2'b00;
      if (i == 1 || i == 3) htrans = 2'b10;
      tick();
      n_cmp++; if ({def_hreadyout, def_hresp} !== exp_seq[i]) begin n_bad++; $display("FAIL b2b_resp step=%0d got=%b exp=%b", i, {def_hreadyout, def_hresp}, exp_seq[i]); end
    end
    // IDLE and BUSY to an unmapped address: zero-wait OKAY.
    htrans = 2'b00; hready = 1'b1;
    tick();
    n_cmp++; if ({def_hreadyout, def_hresp} !== 2'b10) begin n_bad++; $display("FAIL idle_unmapped got=%b exp=10", {def_hreadyout, def_hresp}); end
    htrans = 2'b01;
    tick();
    n_cmp++; if ({def_hreadyout, def_hresp} !== 2'b10) begin n_bad++; $display("FAIL busy_unmapped got=%b exp=10", {def_hreadyout, def_hresp}); end
    // Mapped transfer in the ERR2 address phase.
    htrans = 2'b11;
    tick();
    hready = 1'b0; htrans = 2'b00;
    tick();
    hready = 1'b1; haddr = 32'h0002_0010; htrans = 2'b10;
    tick();
    n_cmp++; if ({def_hreadyout, def_hresp} !== 2'b10) begin n_bad++; $display("FAIL err2_mapped_resp got=%b exp=10", {def_hreadyout, def_hresp}); end
    n_cmp++; if (sel !== 3'b010) begin n_bad++; $display("FAIL err2_mapped_sel got=%b exp=010", sel); end
  endtask

  task automatic test_reset_mid_error();
    haddr = 32'h0007_0000; htrans = 2'b10; hready = 1'b1;
    tick();
    n_cmp++; if ({def_hreadyout, def_hresp} !== 2'b01) begin n_bad++; $display("FAIL rst_mid_err1 got=%b exp=01", {def_hreadyout, def_hresp}); end
    hreset = 1'b1; hready = 1'b0; haddr = 32'h0000_0100;
    tick();
    n_cmp++; if ({def_hreadyout, def_hresp} !== 2'b10) begin n_bad++; $display("FAIL rst_mid_resp got=%b exp=10", {def_hreadyout, def_hresp}); end
    n_cmp++; if (sel !== 3'b011) begin n_bad++; $display("FAIL rst_mid_sel got=%b exp=011", sel); end
    hreset = 1'b0; hready = 1'b1; htrans = 2'b00;
    tick();
  endtask

  task automatic test_random();
    logic [31:0] a;
    logic [2:0]  exp_hsel;
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(4, 0))
        0: a = 32'h0000_0000 | ($urandom & 32'h0000_FFFF);
        1: a = 32'h0001_0000 | ($urandom & 32'h0000_FFFF);
        2: a = 32'h0002_0000 | ($urandom & 32'h0000_FFFF);
        3: a = 32'h0003_0000 + ($urandom & 32'h000F_FFFF);
        default: a = $urandom;
      endcase
      haddr  = a;
      htrans = 2'($urandom_range(3, 0));
      hready = ($urandom_range(3, 0) != 0);
      hreset = ($urandom_range(39, 0) == 0);
      #1;
      exp_hsel = (owner(a) == 0) ? 3'b100 : (owner(a) == 1) ? 3'b010 :
                 (owner(a) == 2) ? 3'b001 : 3'b000;
      n_cmp++; if ({hsel_1, hsel_2, hsel_3} !== exp_hsel) begin n_bad++; $display("FAIL rnd_hsel addr=%h got=%b exp=%b", a, {hsel_1, hsel_2, hsel_3}, exp_hsel); end
      tick();
      n_cmp++; if (sel !== 3'(m_slave)) begin n_bad++; $display("FAIL rnd_sel cycle=%0d got=%b exp=%0d", i, sel, m_slave); end
      n_cmp++; if (def_hreadyout !== (m_err_left != 2)) begin n_bad++; $display("FAIL rnd_hreadyout cycle=%0d got=%b exp=%0d", i, def_hreadyout, (m_err_left != 2)); end
      n_cmp++; if (def_hresp !== (m_err_left != 0)) begin n_bad++; $display("FAIL rnd_hresp cycle=%0d got=%b exp=%0d", i, def_hresp, (m_err_left != 0)); end
`ifdef DECODE_ERR_CNT_EN
      n_cmp++; if (err_count !== 16'(m_cnt)) begin n_bad++; $display("FAIL rnd_err_count cycle=%0d got=%0d exp=%0d", i, err_count, m_cnt); end
`endif
    end
    hreset = 1'b0;
  endtask

`ifdef DECODE_ERR_CNT_EN
  task automatic test_err_count();
    hreset = 1'b1; hready = 1'b1; htrans = 2'b00;
    tick();
    hreset = 1'b0;
    n_cmp++; if (err_count !== 16'd0) begin n_bad++; $display("FAIL cnt_reset got=%0d exp=0", err_count); end
    for (int i = 0; i < 3; i++) begin
      haddr = 32'h0008_0000; htrans = 2'b10; hready = 1'b1;
      tick();
      htrans = 2'b00; hready = 1'b0;
      tick();
      hready = 1'b1;
      tick();
    end
    n_cmp++; if (err_count !== 16'd3) begin n_bad++; $display("FAIL cnt_three got=%0d exp=3", err_count); end
  endtask
`endif

  initial begin
    m_slave = 3; m_err_left = 0; m_cnt = 0;
    test_reset();
    test_mapped_decode();
    test_unmapped_error();
    test_back_to_back();
    test_reset_mid_error();
    test_random();
`ifdef DECODE_ERR_CNT_EN
    test_err_count();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
